// File: rtl/dma_pkg.sv
// dma_pkg: shared types and constants for the word-granular copy engine.
//   dma_state_e    - copy engine state encoding
//   SIGN_MASK_WORD - data-port access mask for an unsigned full-word access
//   ADDR_W         - byte address width of the data-memory port
//   WORD_BYTES     - pointer stride per copied word
//   word_align     - clears the byte-offset bits of an address
package dma_pkg;

  localparam int ADDR_W = 32;
  localparam int WORD_BYTES = 4;
  localparam logic [3:0] SIGN_MASK_WORD = 4'b0111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_DONE
  } dma_state_e;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/dma_copy_engine.sv
// dma_copy_engine: copies word_count 32-bit words from src_addr to dst_addr
// by acting as the requester on the data-memory port (one read, then one
// write, per word).
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for start
// ST_RD_REQ  | read strobe high for one cycle at the source pointer
// ST_RD_WAIT | waiting for the responder to release stall; captures data
// ST_WR_REQ  | write strobe high for one cycle at the destination pointer
// ST_WR_WAIT | waiting for release; advances pointers and the word counter
// ST_DONE    | copy finished; done pulses on the following cycle
//
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   start, src_addr, dst_addr,
//   word_count                 - copy request (sampled only in ST_IDLE)
//   busy, done                 - status; done is a one-cycle pulse
//   mem_addr, mem_write_data,
//   mem_memread, mem_memwrite,
//   mem_sign_mask              - request side of the data-memory port
//   mem_read_data, mem_clk_stall - responder side of the data-memory port
module dma_copy_engine
  import dma_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       src_addr,
  input  logic [31:0]       dst_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_write_data,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic [3:0]        mem_sign_mask,
  input  logic [31:0]       mem_read_data,
  input  logic              mem_clk_stall
);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              first_wait_q, first_wait_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              released;

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    // The responder only raises stall at the edge that samples the strobe,
    // so the first wait cycle cannot be trusted to reflect its state.
    released     = !first_wait_q && !mem_clk_stall;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            src_d   = word_align(src_addr);
            dst_d   = word_align(dst_addr);
            cnt_d   = word_count;
            state_d = ST_RD_REQ;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RD_REQ:  state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (released) begin
          data_d  = mem_read_data;
          state_d = ST_WR_REQ;
        end
      end
      ST_WR_REQ:  state_d = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (released) begin
          src_d   = src_q + ADDR_W'(WORD_BYTES);
          dst_d   = dst_q + ADDR_W'(WORD_BYTES);
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = (cnt_q == CNT_W'(1)) ? ST_DONE : ST_RD_REQ;
        end
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Port outputs are registered from the next state so each strobe is
    // high for exactly the cycle its request state occupies.
    rd_d   = (state_d == ST_RD_REQ);
    wr_d   = (state_d == ST_WR_REQ);
    addr_d = addr_q;
    if (rd_d) begin
      addr_d = src_d;
    end else if (wr_d) begin
      addr_d = dst_d;
    end
    busy_d       = (state_d != ST_IDLE);
    // done trails the DONE state by one cycle, after busy has dropped.
    done_d       = (state_q == ST_DONE);
    first_wait_d = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      first_wait_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      first_wait_q <= first_wait_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = data_q;
  assign mem_memread    = rd_q;
  assign mem_memwrite   = wr_q;
  assign mem_sign_mask  = SIGN_MASK_WORD;

endmodule

// File: tb/tb_dma_copy_engine.sv
// Bench for dma_copy_engine: behavioural responder plus a word-list model
// of the copy (expected transactions and done timing from plain arithmetic).
module tb_dma_copy_engine;

  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [31:0]       src_addr;
  logic [31:0]       dst_addr;
  logic [CNT_W-1:0]  word_count;
  logic              busy;
  logic              done;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_write_data;
  logic              mem_memread;
  logic              mem_memwrite;
  logic [3:0]        mem_sign_mask;
  logic [31:0]       mem_read_data = 32'h0;
  logic              mem_clk_stall = 1'b0;

  dma_copy_engine #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .word_count(word_count), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data),
    .mem_clk_stall(mem_clk_stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h0) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  // ---------------- responder ----------------
  logic [31:0] resp_mem [logic [31:0]];
  logic        r_busy = 1'b0;
  logic        r_rd = 1'b0;
  logic [31:0] r_addr = 32'h0;
  int          r_cnt = 0;
  int          rd_total = 0;
  int          ext_rd_target = -1;
  int          ext_len_v = 2;

  function automatic logic [31:0] resp_rd(input logic [31:0] a);
    return resp_mem.exists(a) ? resp_mem[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (r_busy) begin
      if (r_cnt <= 1) begin
        r_busy        <= 1'b0;
        mem_clk_stall <= 1'b0;
        if (r_rd) mem_read_data <= resp_rd(r_addr);
      end else begin
        r_cnt         <= r_cnt - 1;
        mem_read_data <= $urandom;
      end
    end else if (mem_memread || mem_memwrite) begin
      r_busy        <= 1'b1;
      mem_clk_stall <= 1'b1;
      r_addr        <= mem_addr;
      r_rd          <= mem_memread;
      mem_read_data <= $urandom;
      if (mem_memread) begin
        r_cnt    <= (rd_total == ext_rd_target) ? ext_len_v : 2;
        rd_total <= rd_total + 1;
      end else begin
        r_cnt    <= 2;
        resp_mem[mem_addr] = mem_write_data;
      end
    end
  end

  // ---------------- model and compare ----------------
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] model_mem [logic [31:0]];
  int          checks = 0;
  int          errors = 0;
  bit          act_on = 1'b0;
  int          s_cyc = 0;
  int          tot = 0;
  int          done_cyc = -1;
  int          busy_n = 0;
  int          strb_n = 0;
  bit          prev_strobe = 1'b0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;
  logic [31:0] last_rd_addr = 32'h0;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_word(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", nm, cyc, act, exp);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_memread", {31'b0, mem_memread}, 32'd0);
    chk("rst_memwrite", {31'b0, mem_memwrite}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_write_data, 32'h0);
    chk("rst_sign_mask", {28'b0, mem_sign_mask}, 32'h7);
  endtask

  task automatic check_cycle();
    int  rel;
    bit  eb, ed;
    txn_t t;
    if (reset) return;
    rel = cyc - s_cyc;
    eb  = act_on && rel >= 1 && rel < tot;
    ed  = act_on && rel == tot;
    chk("sign_mask", {28'b0, mem_sign_mask}, 32'h7);
    chk("busy", {31'b0, busy}, {31'b0, eb});
    chk("done", {31'b0, done}, {31'b0, ed});
    if (done) done_cyc = cyc;
    if (busy) busy_n++;
    if (mem_memread || mem_memwrite) begin
      strb_n++;
      chk("strobe_exclusive", {31'b0, mem_memread & mem_memwrite}, 32'd0);
      chk("strobe_held", {31'b0, prev_strobe}, 32'd0);
      chk("txn_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() != 0) begin
        t = exp_q.pop_front();
        chk("txn_is_write", {31'b0, mem_memwrite}, {31'b0, t.wr});
        chk("txn_addr", mem_addr, t.addr);
        if (t.wr) begin
          chk("txn_wdata", mem_write_data, t.data);
          last_wr_addr = mem_addr;
          last_wr_data = mem_write_data;
        end else begin
          last_rd_addr = mem_addr;
        end
      end
    end
    prev_strobe = mem_memread || mem_memwrite;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                          input int ext_rel, input int elen, input int mid,
                          input int lit_done, input int lit_busy, input int lit_strb,
                          input bit abort3);
    logic [31:0] ov [logic [31:0]];
    logic [31:0] sa, da, a, v;
    int          g, busy0, strb0, rel;
    txn_t        t;
    g = 0;
    while ((busy || r_busy) && g < 100) begin
      step();
      g++;
    end
    chk("idle_before_start", {31'b0, busy | r_busy}, 32'd0);
    sa = {s[31:2], 2'b00};
    da = {d[31:2], 2'b00};
    for (int i = 0; i < n; i++) begin
      a = sa + 32'(4 * i);
      v = ov.exists(a) ? ov[a] : model_rd(a);
      t.wr = 1'b0; t.addr = a; t.data = 32'h0;
      exp_q.push_back(t);
      a = da + 32'(4 * i);
      ov[a] = v;
      t.wr = 1'b1; t.addr = a; t.data = v;
      exp_q.push_back(t);
    end
    tot = (n == 0) ? 2 : 8 * n + 2;
    if (ext_rel >= 0 && ext_rel < n) begin
      tot += elen - 2;
      ext_rd_target = rd_total + ext_rel;
    end else begin
      ext_rd_target = -1;
    end
    ext_len_v  = elen;
    start      = 1'b1;
    src_addr   = s;
    dst_addr   = d;
    word_count = CNT_W'(n);
    s_cyc      = cyc;
    act_on     = 1'b1;
    done_cyc   = -1;
    busy0      = busy_n;
    strb0      = strb_n;
    step();
    src_addr   = $urandom;
    dst_addr   = $urandom;
    word_count = CNT_W'($urandom);
    while (cyc - s_cyc <= tot + 1) begin
      rel   = cyc - s_cyc;
      start = 1'b0;
      if (abort3 && rel == 3) begin
        reset = 1'b1;
        #1;
        check_reset_vals();
        act_on = 1'b0;
        exp_q.delete();
        step();
        step();
        reset = 1'b0;
        prev_strobe = 1'b0;
        return;
      end
      if ((mid == 1 && rel == 3) || (mid == 2 && rel == tot - 1)) begin
        start      = 1'b1;
        word_count = CNT_W'($urandom);
        src_addr   = $urandom;
      end
      step();
    end
    start = 1'b0;
    chk("txn_queue_drained", exp_q.size(), 32'd0);
    exp_q.delete();
    foreach (ov[k]) model_mem[k] = ov[k];
    chk("done_seen_rel", (done_cyc < 0) ? 32'hFFFFFFFF : 32'(done_cyc - s_cyc), 32'(tot));
    if (lit_done >= 0) chk("lit_done_cycle", 32'(done_cyc - s_cyc), 32'(lit_done));
    if (lit_busy >= 0) chk("lit_busy_cycles", 32'(busy_n - busy0), 32'(lit_busy));
    if (lit_strb >= 0) chk("lit_strobes", 32'(strb_n - strb0), 32'(lit_strb));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, er, md;
    logic [31:0] s, d;
    reset = 1'b1; start = 1'b0; src_addr = 32'h0; dst_addr = 32'h0; word_count = '0;
    #1;
    check_reset_vals();
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;
    step();

    run_copy(32'h0, 32'h100, 1, -1, 2, 0, 10, 9, 2, 1'b0);
    chk("lit_wr_data", last_wr_data, 32'hDEADBEEF);
    chk("lit_wr_addr", last_wr_addr, 32'h100);
    run_copy(32'h40, 32'h80, 4, -1, 2, 0, 34, 33, 8, 1'b0);
    chk("lit_last_rd", last_rd_addr, 32'h4C);
    chk("lit_last_wr", last_wr_addr, 32'h8C);
    run_copy(32'h123, 32'h456, 0, -1, 2, 2, 2, 1, 0, 1'b0);
    run_copy(32'h200, 32'h300, 2, -1, 2, 1, 18, 17, 4, 1'b0);
    run_copy(32'hFFFFFFFC, 32'h3, 2, -1, 2, 0, 18, 17, 4, 1'b0);
    chk("lit_wrap_rd", last_rd_addr, 32'h0);
    chk("lit_misalign_wr", last_wr_addr, 32'h4);
    run_copy(32'h500, 32'h600, 2, 1, 7, 0, 23, 22, 4, 1'b0);
    run_copy(32'h700, 32'h800, 3, -1, 2, 0, -1, -1, -1, 1'b1);
    run_copy(32'h700, 32'h800, 3, -1, 2, 0, 26, 25, 6, 1'b0);

    for (int r = 0; r < 20; r++) begin
      n  = $urandom_range(0, 6);
      s  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 511));
      d  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 511));
      er = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 5) : -1;
      md = (n == 0) ? 2 * $urandom_range(0, 1) : $urandom_range(0, 2);
      run_copy(s, d, n, er, $urandom_range(1, 7), md, -1, -1, 2 * n, 1'b0);
    end

    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_copy_engine.md
# dma_copy_engine

Word-granular memory-to-memory copy engine that acts as a request initiator on the data-memory port (memread/memwrite/addr/write_data/sign_mask in, read_data/clk_stall back). It is the requesting end of the same handshake the data cache answers for the core. While `busy`, it owns the data-memory port; the core-side mux outside this block selects it. It copies `word_count` 32-bit words from `src_addr` to `dst_addr`.

## Interface

Parameters:
- CNT_W, 16, width of the word-count field and the internal down-counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state and returns to IDLE.
- start  in  1  one-cycle request to begin a copy; sampled only in IDLE.
- src_addr  in  32  source byte address; bits [1:0] are forced to 00.
- dst_addr  in  32  destination byte address; bits [1:0] are forced to 00.
- word_count  in  CNT_W  number of words to copy.
- busy  out  1  high from the cycle after `start` is accepted until DONE is left.
- done  out  1  one-cycle pulse when the copy completes.
- mem_addr  out  32  request address.
- mem_write_data  out  32  write data; holds the word captured by the last read.
- mem_memread  out  1  read request strobe.
- mem_memwrite  out  1  write request strobe.
- mem_sign_mask  out  4  constant 4'b0111 (unsigned full word).
- mem_read_data  in  32  read return from the responder.
- mem_clk_stall  in  1  responder busy flag.

## Operation

- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
- IDLE:
  - start=1 and word_count≠0: latch src/dst with [1:0]=00, load the counter with word_count, go to RD_REQ.
  - start=1 and word_count=0: go to DONE with no memory traffic.
- RD_REQ (exactly one cycle): mem_memread=1, mem_addr=src pointer; then RD_WAIT.
- RD_WAIT:
  - Strobes are 0; mem_addr holds.
  - The first cycle after RD_REQ is always a wait, because the responder raises stall at the sampling edge.
  - Then wait while mem_clk_stall=1. On the first cycle with mem_clk_stall=0, capture mem_read_data into the data register, go to WR_REQ.
- WR_REQ (exactly one cycle): mem_memwrite=1, mem_addr=dst pointer, mem_write_data=data register; then WR_WAIT.
- WR_WAIT:
  - Same stall rule as RD_WAIT.
  - On release: src+=4, dst+=4, counter-=1.
  - If the counter was 1, go to DONE; otherwise go to RD_REQ.
- DONE: done=1 for one cycle, then IDLE.
- Request strobes are never held for more than one cycle. The responder samples them every cycle it is idle, so holding them would issue duplicate transactions.
- Pointer increment wraps modulo 2^32. The counter never underflows.
- start outside IDLE (including in DONE) is ignored.
- The 0x2000 LED address gets no special treatment; a copy touching it writes the LED register.

## Timing

- Reset values: busy=0, done=0, mem_memread=0, mem_memwrite=0, mem_addr=0, mem_write_data=0, mem_sign_mask=4'b0111. State=IDLE, counter=0.
- Strobes and mem_addr are registered outputs (driven from state and registers, no combinational path from inputs).
- With the standard responder (request edge E, stall high E+1..E+3, released at E+3), one word takes 8 cycles: RD_REQ 1, RD_WAIT 3, WR_REQ 1, WR_WAIT 3.
- Total copy time is 8·N + 2 cycles from the start edge to the done pulse, including the DONE cycle.
- Reset mid-copy aborts immediately: strobes drop asynchronously and no done pulse follows. A responder transaction already in flight completes on its own; the engine ignores it.

## Structure

- Shared package `dma_pkg`:
  - state enum;
  - SIGN_MASK_WORD=4'b0111;
  - ADDR_W=32;
  - WORD_BYTES=4.
- Single module. No sub-module is warranted; the counter and pointers are inline registers.

## Test plan

- Reset mid-RD_WAIT, with a behavioural responder model (stall high 3 cycles after each request, read_data valid on release) → all outputs return to reset values, and the next start=1 runs a full copy correctly.
- src=0x0, dst=0x100, count=1, memory[0]=0xDEADBEEF → one read at 0x0, one write of 0xDEADBEEF at 0x100, done at cycle 10, busy high cycles 1–9.
- count=4, src=0x40, dst=0x80 → reads 0x40,0x44,0x48,0x4C interleaved with writes to 0x80..0x8C; each strobe high exactly 1 cycle; done at cycle 34.
- count=0 → no strobes, done pulse 2 cycles after start; start pulsed again during busy of a count=2 copy → ignored, exactly 2 read/write pairs occur.
- src=0xFFFFFFFC, dst=0x3 (misaligned), count=2 → reads 0xFFFFFFFC then 0x00000000; writes 0x0 then 0x4.
- Responder stall extended to 7 cycles on the second read → engine waits without re-strobing; data captured only on release.
